// File: rtl/gpu_cdb_pkg.sv
// Shared field widths and the packed writeback entry carried between MEM and the CDB.
package gpu_cdb_pkg;

  localparam int unsigned WARP_W  = 3;
  localparam int unsigned DST_W   = 5;
  localparam int unsigned DATA_W  = 256;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned MASK_W  = 8;

  typedef struct packed {
    logic [WARP_W-1:0]  warp_id;
    logic [DST_W-1:0]   dst;
    logic [DATA_W-1:0]  data;
    logic [INSTR_W-1:0] instr;
    logic [MASK_W-1:0]  active_mask;
  } wb_entry_t;

  localparam int unsigned ENTRY_W = $bits(wb_entry_t);

endpackage

// File: rtl/wb_fifo_mem.sv
// Entry storage for the MEM writeback buffer: one synchronous write port,
// one asynchronous read port. Contents are not reset.
module wb_fifo_mem
  import gpu_cdb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  wb_entry_t       wdata,
  input  logic [AW-1:0]   raddr,
  output wb_entry_t       rdata
);

  wb_entry_t mem [DEPTH];

  // Write the incoming entry at the write pointer.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/cdb_mem_wb_buffer.sv
// MEM-stage writeback buffer in front of the common data bus. The ALU owns the
// CDB when it asserts RegWrite_ALU_CDB; buffered MEM writebacks drain in order
// otherwise, with a starvation request raised after STARVE_LIMIT lost cycles.
// Optional macro CDB_WB_BYPASS_EN: an empty buffer with an idle ALU forwards
// the MEM writeback onto the CDB in the same cycle without storing it.
module cdb_mem_wb_buffer
  import gpu_cdb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     RegWrite_MEM_WB,
  input  logic [WARP_W-1:0]        WarpID_MEM_WB,
  input  logic [DST_W-1:0]         Dst_MEM_WB,
  input  logic [DATA_W-1:0]        Dst_Data_MEM_WB,
  input  logic [INSTR_W-1:0]       Instr_MEM_WB,
  input  logic [MASK_W-1:0]        ActiveMask_MEM_WB,
  input  logic                     RegWrite_ALU_CDB,
  output logic                     RegWrite_MEM_CDB,
  output logic [WARP_W-1:0]        WarpID_MEM_CDB,
  output logic [DST_W-1:0]         Dst_MEM_CDB,
  output logic [DATA_W-1:0]        Dst_Data_MEM_CDB,
  output logic [INSTR_W-1:0]       Instr_MEM_CDB,
  output logic [MASK_W-1:0]        ActiveMask_MEM_CDB,
  output logic                     Stall_WB_MEM,
  output logic                     Starve_CDB_ALU,
  output logic                     Overflow_WB,
  output logic [$clog2(DEPTH):0]   Count_WB
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt, starve_cnt_nxt;
  logic          starve_q, overflow_q;
  logic          not_empty, full, bypass, push, pop, starve_cond;
  wb_entry_t     in_entry, head_entry, out_entry;

  assign in_entry = '{warp_id:     WarpID_MEM_WB,
                      dst:         Dst_MEM_WB,
                      data:        Dst_Data_MEM_WB,
                      instr:       Instr_MEM_WB,
                      active_mask: ActiveMask_MEM_WB};

  assign not_empty = (count != '0);
  assign full      = (count == DEPTH_C);

`ifdef CDB_WB_BYPASS_EN
  // Gated by rst_n so the combinational forward path stays quiet in reset.
  assign bypass = rst_n && !not_empty && RegWrite_MEM_WB && !RegWrite_ALU_CDB;
`else
  assign bypass = 1'b0;
`endif

  // Acceptance uses start-of-cycle occupancy: a full buffer drops the push
  // even if the head pops on the same edge.
  assign push        = RegWrite_MEM_WB && !full && !bypass;
  assign pop         = not_empty && !RegWrite_ALU_CDB;
  assign starve_cond = not_empty && RegWrite_ALU_CDB;

  wb_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (in_entry),
    .raddr (rd_ptr),
    .rdata (head_entry)
  );

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Next starvation count: saturating while the ALU blocks a non-empty buffer.
  always_comb begin
    starve_cnt_nxt = '0;
    if (starve_cond)
      starve_cnt_nxt = (starve_cnt == LIMIT_C) ? starve_cnt : starve_cnt + 1'b1;
  end

  // Starvation counter and request; the request rises on the edge where the
  // counter reaches the limit and holds until the head finally pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
      starve_q   <= 1'b0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      if (pop)
        starve_q <= 1'b0;
      else if (starve_cnt_nxt == LIMIT_C)
        starve_q <= 1'b1;
    end
  end

  // Sticky overflow on any push attempt against a full buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      overflow_q <= 1'b0;
    else if (RegWrite_MEM_WB && full)
      overflow_q <= 1'b1;
  end

  // CDB-facing entry: head when buffered, forwarded input on bypass, else zero.
  always_comb begin
    out_entry = '0;
    if (not_empty)
      out_entry = head_entry;
    else if (bypass)
      out_entry = in_entry;
  end

  assign RegWrite_MEM_CDB   = not_empty || bypass;
  assign WarpID_MEM_CDB     = out_entry.warp_id;
  assign Dst_MEM_CDB        = out_entry.dst;
  assign Dst_Data_MEM_CDB   = out_entry.data;
  assign Instr_MEM_CDB      = out_entry.instr;
  assign ActiveMask_MEM_CDB = out_entry.active_mask;
  assign Stall_WB_MEM       = full;
  assign Starve_CDB_ALU     = starve_q;
  assign Overflow_WB        = overflow_q;
  assign Count_WB           = count;

endmodule

// File: tb/tb_cdb_mem_wb_buffer.sv
// Scoreboard bench for cdb_mem_wb_buffer (default build, bypass disabled).
module tb_cdb_mem_wb_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         RegWrite_MEM_WB;
  logic [2:0]   WarpID_MEM_WB;
  logic [4:0]   Dst_MEM_WB;
  logic [255:0] Dst_Data_MEM_WB;
  logic [31:0]  Instr_MEM_WB;
  logic [7:0]   ActiveMask_MEM_WB;
  logic         RegWrite_ALU_CDB;
  logic         RegWrite_MEM_CDB;
  logic [2:0]   WarpID_MEM_CDB;
  logic [4:0]   Dst_MEM_CDB;
  logic [255:0] Dst_Data_MEM_CDB;
  logic [31:0]  Instr_MEM_CDB;
  logic [7:0]   ActiveMask_MEM_CDB;
  logic         Stall_WB_MEM;
  logic         Starve_CDB_ALU;
  logic         Overflow_WB;
  logic [2:0]   Count_WB;

  typedef struct {
    logic [2:0]   w;
    logic [4:0]   d;
    logic [255:0] data;
    logic [31:0]  i;
    logic [7:0]   m;
  } exp_t;

  exp_t exp_q[$];
  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  cdb_mem_wb_buffer #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .RegWrite_MEM_WB    (RegWrite_MEM_WB),
    .WarpID_MEM_WB      (WarpID_MEM_WB),
    .Dst_MEM_WB         (Dst_MEM_WB),
    .Dst_Data_MEM_WB    (Dst_Data_MEM_WB),
    .Instr_MEM_WB       (Instr_MEM_WB),
    .ActiveMask_MEM_WB  (ActiveMask_MEM_WB),
    .RegWrite_ALU_CDB   (RegWrite_ALU_CDB),
    .RegWrite_MEM_CDB   (RegWrite_MEM_CDB),
    .WarpID_MEM_CDB     (WarpID_MEM_CDB),
    .Dst_MEM_CDB        (Dst_MEM_CDB),
    .Dst_Data_MEM_CDB   (Dst_Data_MEM_CDB),
    .Instr_MEM_CDB      (Instr_MEM_CDB),
    .ActiveMask_MEM_CDB (ActiveMask_MEM_CDB),
    .Stall_WB_MEM       (Stall_WB_MEM),
    .Starve_CDB_ALU     (Starve_CDB_ALU),
    .Overflow_WB        (Overflow_WB),
    .Count_WB           (Count_WB)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] data_for(input logic [4:0] dst);
    logic [7:0] b;
    b = (dst == 5'd5) ? 8'hA5 : {3'b011, dst};
    return {32{b}};
  endfunction

  // One clock of stimulus; store=1 means the bench expects this push to be kept.
  task automatic step(input logic we, input logic [4:0] dst, input logic alu, input logic store);
    exp_t e;
    RegWrite_MEM_WB   = we;
    Dst_MEM_WB        = dst;
    WarpID_MEM_WB     = dst[2:0];
    Dst_Data_MEM_WB   = data_for(dst);
    Instr_MEM_WB      = {16'hC0DE, 11'h0, dst};
    ActiveMask_MEM_WB = {3'b101, dst};
    RegWrite_ALU_CDB  = alu;
    if (we && store) begin
      e.w = dst[2:0]; e.d = dst; e.data = data_for(dst);
      e.i = {16'hC0DE, 11'h0, dst}; e.m = {3'b101, dst};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    RegWrite_MEM_WB = 1'b0;
  endtask

  // Monitor: a pop happens on the next edge whenever the head is valid and the ALU is idle.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && RegWrite_MEM_CDB === 1'b1 && RegWrite_ALU_CDB === 1'b0) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_pop: got dst %0h expected no entry", Dst_MEM_CDB);
      end else begin
        e = exp_q.pop_front();
        chk("pop_dst", 256'(Dst_MEM_CDB), 256'(e.d));
        chk("pop_warp_instr_mask", 256'({WarpID_MEM_CDB, Instr_MEM_CDB, ActiveMask_MEM_CDB}),
            256'({e.w, e.i, e.m}));
        chk("pop_data", Dst_Data_MEM_CDB, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    RegWrite_MEM_WB = 1'b0; WarpID_MEM_WB = '0; Dst_MEM_WB = '0; Dst_Data_MEM_WB = '0;
    Instr_MEM_WB = '0; ActiveMask_MEM_WB = '0; RegWrite_ALU_CDB = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rst_valid", 256'(RegWrite_MEM_CDB), 256'(0));
    chk("rst_count", 256'(Count_WB), 256'(0));
    chk("rst_stall", 256'(Stall_WB_MEM), 256'(0));
    chk("rst_ovf", 256'(Overflow_WB), 256'(0));
    chk("rst_starve", 256'(Starve_CDB_ALU), 256'(0));
    chk("rst_dst", 256'(Dst_MEM_CDB), 256'(0));
    rst_n = 1'b1;

    // Single writeback, one cycle latency, popped on the following edge.
    step(1'b1, 5'd5, 1'b0, 1'b1);
    chk("lat_valid", 256'(RegWrite_MEM_CDB), 256'(1));
    chk("lat_dst", 256'(Dst_MEM_CDB), 256'(5));
    chk("lat_count", 256'(Count_WB), 256'(1));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("drain_count", 256'(Count_WB), 256'(0));
    chk("drain_valid", 256'(RegWrite_MEM_CDB), 256'(0));
    chk("empty_data_zero", Dst_Data_MEM_CDB, 256'(0));

    // Fill under ALU ownership, then overflow with and without a same-edge pop.
    step(1'b1, 5'd11, 1'b1, 1'b1);
    step(1'b1, 5'd12, 1'b1, 1'b1);
    step(1'b1, 5'd13, 1'b1, 1'b1);
    step(1'b1, 5'd14, 1'b1, 1'b1);
    chk("full_count", 256'(Count_WB), 256'(4));
    chk("full_stall", 256'(Stall_WB_MEM), 256'(1));
    chk("full_ovf", 256'(Overflow_WB), 256'(0));
    step(1'b1, 5'd15, 1'b1, 1'b0);
    chk("ovf_count", 256'(Count_WB), 256'(4));
    chk("ovf_set", 256'(Overflow_WB), 256'(1));
    step(1'b1, 5'd16, 1'b0, 1'b0);
    chk("full_pushpop_count", 256'(Count_WB), 256'(3));
    chk("full_pushpop_stall", 256'(Stall_WB_MEM), 256'(0));
    for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("drain2_count", 256'(Count_WB), 256'(0));
    chk("ovf_sticky", 256'(Overflow_WB), 256'(1));

    // Order across pointer wrap with simultaneous push and pop.
    step(1'b1, 5'd1, 1'b1, 1'b1);
    step(1'b1, 5'd2, 1'b1, 1'b1);
    step(1'b1, 5'd3, 1'b1, 1'b1);
    step(1'b1, 5'd4, 1'b0, 1'b1);
    chk("pushpop_count", 256'(Count_WB), 256'(3));
    step(1'b1, 5'd5, 1'b0, 1'b1);
    step(1'b1, 5'd6, 1'b0, 1'b1);
    chk("pushpop_count2", 256'(Count_WB), 256'(3));
    for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("drain3_count", 256'(Count_WB), 256'(0));

    // Starvation: eight blocked cycles raise the request, a pop clears it.
    step(1'b1, 5'd20, 1'b1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step(1'b0, 5'd0, 1'b1, 1'b0);
      chk($sformatf("starve_c%0d", k), 256'(Starve_CDB_ALU), 256'(k == 8));
    end
    chk("starve_count", 256'(Count_WB), 256'(1));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("starve_clear", 256'(Starve_CDB_ALU), 256'(0));
    chk("starve_pop_count", 256'(Count_WB), 256'(0));

    // Asynchronous reset mid-cycle with three entries buffered.
    step(1'b1, 5'd21, 1'b1, 1'b1);
    step(1'b1, 5'd22, 1'b1, 1'b1);
    step(1'b1, 5'd23, 1'b1, 1'b1);
    chk("prerst_count", 256'(Count_WB), 256'(3));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("arst_valid", 256'(RegWrite_MEM_CDB), 256'(0));
    chk("arst_count", 256'(Count_WB), 256'(0));
    chk("arst_ovf", 256'(Overflow_WB), 256'(0));
    chk("arst_stall", 256'(Stall_WB_MEM), 256'(0));
    chk("arst_starve", 256'(Starve_CDB_ALU), 256'(0));
    chk("arst_fields", 256'({WarpID_MEM_CDB, Dst_MEM_CDB, Instr_MEM_CDB, ActiveMask_MEM_CDB}), 256'(0));
    chk("arst_data", Dst_Data_MEM_CDB, 256'(0));
    RegWrite_ALU_CDB = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Normal operation resumes after reset.
    step(1'b1, 5'd9, 1'b0, 1'b1);
    chk("post_rst_dst", 256'(Dst_MEM_CDB), 256'(9));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("post_rst_count", 256'(Count_WB), 256'(0));
    step(1'b0, 5'd0, 1'b0, 1'b0);
    chk("scoreboard_empty", 256'(exp_q.size()), 256'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/cdb_mem_wb_buffer.md
CDB_MEM_WB_BUFFER -- requirements
Module: cdb_mem_wb_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of buffered MEM writeback entries; DEPTH SHALL be a power of two, 2..8.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, meaning the number of consecutive ALU-won cycles with a non-empty buffer before starvation relief.
REQ-003 SHALL have ports, one per line, in this order:
 clk  in  1  single clock, rising edge
 rst_n  in  1  asynchronous, active-low reset
 RegWrite_MEM_WB  in  1  MEM stage presents a writeback this cycle
 WarpID_MEM_WB  in  3  hardware warp ID
 Dst_MEM_WB  in  5  destination register
 Dst_Data_MEM_WB  in  256  eight 32-bit lanes of write data
 Instr_MEM_WB  in  32  instruction word
 ActiveMask_MEM_WB  in  8  lane mask
 RegWrite_ALU_CDB  in  1  ALU holds the CDB this cycle; ALU has priority
 RegWrite_MEM_CDB  out  1  head entry valid toward CDB
 WarpID_MEM_CDB / Dst_MEM_CDB / Dst_Data_MEM_CDB / Instr_MEM_CDB / ActiveMask_MEM_CDB  out  3/5/256/32/8  head entry fields
 Stall_WB_MEM  out  1  buffer full; MEM must hold its writeback
 Starve_CDB_ALU  out  1  request for ALU to withhold its writeback next cycle
 Overflow_WB  out  1  sticky flag: a push was attempted while full
 Count_WB  out  $clog2(DEPTH)+1  current occupancy

Function
REQ-004 SHALL implement an in-order FIFO; each entry holds {WarpID, Dst, Data, Instr, ActiveMask}.
REQ-005 Push SHALL occur on a rising edge when RegWrite_MEM_WB=1 and Count_WB<DEPTH; a push is based on occupancy at the start of the cycle, so a push while full SHALL be dropped even if a pop occurs in the same cycle.
REQ-006 A dropped push SHALL set Overflow_WB to 1, and Overflow_WB SHALL stay 1 until reset.
REQ-007 RegWrite_MEM_CDB SHALL be 1 whenever Count_WB>0; the output fields SHALL equal the head entry. When Count_WB=0 (and no bypass is active), the output fields SHALL be 0.
REQ-008 Pop SHALL occur on a rising edge when RegWrite_MEM_CDB=1 and RegWrite_ALU_CDB=0. The head SHALL be held unchanged while the ALU holds the CDB.
REQ-009 Simultaneous push and pop with 0<Count_WB<DEPTH SHALL leave Count_WB unchanged and preserve order.
REQ-010 Read and write pointers SHALL be $clog2(DEPTH) bits wide and wrap modulo DEPTH; Count_WB SHALL be a separate counter.
REQ-011 Stall_WB_MEM SHALL equal (Count_WB==DEPTH), driven combinationally from registered state.
REQ-012 The starvation counter SHALL increment each cycle with Count_WB>0 and RegWrite_ALU_CDB=1, and SHALL clear on any cycle without that condition, including a pop; it SHALL saturate at STARVE_LIMIT.
REQ-013 Starve_CDB_ALU SHALL be a registered output, 1 in the cycle after the counter reaches STARVE_LIMIT and until the next pop.

Reset
REQ-014 While rst_n=0, asynchronously: pointers=0, Count_WB=0, starvation counter=0, Starve_CDB_ALU=0, Overflow_WB=0, RegWrite_MEM_CDB=0, all output fields=0, Stall_WB_MEM=0.
REQ-015 Reset mid-operation SHALL discard all entries; entry storage need not be cleared.

Configuration
REQ-016 With CDB_WB_BYPASS_EN defined: when Count_WB=0, RegWrite_MEM_WB=1 and RegWrite_ALU_CDB=0, the input SHALL be driven onto the *_MEM_CDB outputs in the same cycle with RegWrite_MEM_CDB=1, and SHALL NOT be stored.
REQ-017 Without CDB_WB_BYPASS_EN: every writeback SHALL be stored, giving a minimum latency of 1 cycle from push to RegWrite_MEM_CDB=1.

Structure
REQ-018 Field widths (WARP_W=3, DST_W=5, DATA_W=256, INSTR_W=32, MASK_W=8) and a packed wb_entry_t typedef SHALL live in the shared package gpu_cdb_pkg.
REQ-019 Storage SHALL be a sub-module, wb_fifo_mem (DEPTH x entry width, one write port, one asynchronous read port); the control logic SHALL live in cdb_mem_wb_buffer.

Verification
REQ-020 Without bypass: push Dst=5, Data=0xA5 replicated, with ALU idle -> next cycle RegWrite_MEM_CDB=1, Dst_MEM_CDB=5; the following edge pops it and Count_WB returns to 0.
REQ-021 Hold RegWrite_ALU_CDB=1 and push 4 entries -> Count_WB=4 and Stall_WB_MEM=1; a 5th push sets Overflow_WB=1 and Count_WB stays 4.
REQ-022 Order across wrap: 6 pushes with interleaved pops, Dst=1..6 -> output sequence is 1..6 exactly.
REQ-023 With RegWrite_ALU_CDB=1 for 8 cycles and buffer non-empty -> Starve_CDB_ALU=1 on cycle 9; release the ALU -> pop occurs and Starve_CDB_ALU returns to 0 the next cycle.
REQ-024 With CDB_WB_BYPASS_EN, empty buffer and ALU idle: push Dst=7 -> same cycle RegWrite_MEM_CDB=1, Dst_MEM_CDB=7, and Count_WB stays 0.
REQ-025 Assert rst_n=0 mid-cycle with Count_WB=3 -> all outputs go to 0 immediately, without waiting for a clock edge.
